// File: rtl/ifetch_stage.sv
// ifetch_stage: MIPS instruction-fetch stage.
// Drives the combinational instruction memory from the PC register and
// captures the returned word into the IF/ID register. Applies decode
// redirects with delay-slot semantics and halts on a jump to HALT_ADDR.
// Optional feature macro: IFETCH_ALIGN_CHECK_EN (trap misaligned redirects
// into a FAULT state; when undefined, redirect targets are word-aligned).
module ifetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        active,
  output logic        fault,
  output logic [31:0] fault_addr
);

`ifdef IFETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_FAULT  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1
  } state_t;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc_inc;
  logic [31:0] w_target;
  logic        r_id_valid;
  logic        w_id_valid_nxt;
  logic        w_capture;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        w_misaligned;
  logic        w_fault_set;
  logic        r_fault;
  logic [31:0] r_fault_addr;
`endif

  // Sequential fetch address; wraps modulo 2^32 and never halts by itself.
  assign w_pc_inc = r_pc + 32'd4;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign w_target     = redirect_target;
  assign w_misaligned = |redirect_target[1:0];
`else
  // Without the trap, low target bits are simply dropped.
  assign w_target = redirect_target & 32'hFFFF_FFFC;
`endif

  // Next-state, next-PC and capture decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_id_valid_nxt = r_id_valid;
    w_capture      = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    w_fault_set    = 1'b0;
`endif
    case (r_state)
      S_RUN: begin
        // A stalled cycle holds everything and ignores the redirect; decode
        // keeps it asserted so it is taken once the stall drops.
        if (!stall) begin
          // Whatever sits at IF is captured: sequential word or delay slot.
          w_capture      = 1'b1;
          w_id_valid_nxt = 1'b1;
          if (redirect_valid) begin
`ifdef IFETCH_ALIGN_CHECK_EN
            if (w_misaligned) begin
              w_state_nxt = S_FAULT;
              w_pc_nxt    = w_pc_inc;
              w_fault_set = 1'b1;
            end else begin
              w_pc_nxt = w_target;
              if (w_target == HALT_ADDR) w_state_nxt = S_HALTED;
            end
`else
            w_pc_nxt = w_target;
            if (w_target == HALT_ADDR) w_state_nxt = S_HALTED;
`endif
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end
      end
      S_HALTED: begin
        w_id_valid_nxt = 1'b0;
      end
`ifdef IFETCH_ALIGN_CHECK_EN
      S_FAULT: begin
        w_id_valid_nxt = 1'b0;
      end
`endif
      default: begin
        w_state_nxt    = S_RUN;
        w_id_valid_nxt = 1'b0;
      end
    endcase
  end

  // State, PC and IF/ID register; reset overrides stall and redirect.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_VECTOR;
      r_id_valid <= 1'b0;
      r_id_instr <= 32'd0;
      r_id_pc    <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_id_valid <= w_id_valid_nxt;
      if (w_capture) begin
        r_id_instr <= instr_readdata;
        r_id_pc    <= r_pc;
      end
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  // Sticky fault flag and the target that caused it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fault      <= 1'b0;
      r_fault_addr <= 32'd0;
    end else if (w_fault_set) begin
      r_fault      <= 1'b1;
      r_fault_addr <= w_target;
    end
  end

  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;
`else
  assign fault      = 1'b0;
  assign fault_addr = 32'd0;
`endif

  assign instr_address = r_pc;
  assign id_valid      = r_id_valid;
  assign id_instr      = r_id_instr;
  assign id_pc         = r_id_pc;
  assign active        = (r_state == S_RUN);

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage with a combinational memory model.
module tb_ifetch_stage;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        active;
  logic        fault;
  logic [31:0] fault_addr;

  int n_chk  = 0;
  int n_pass = 0;

  ifetch_stage dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .instr_address(instr_address), .instr_readdata(instr_readdata),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .active(active), .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  assign instr_readdata = mem(instr_address);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, ".vld"}, {31'd0, id_valid}, {31'd0, v});
    chk({tag, ".pc"}, id_pc, pc);
    if (v) chk({tag, ".ins"}, id_instr, mem(pc));
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    step(); step();
    reset_n = 1'b1;
    // reset values
    chk("rst.addr", instr_address, 32'hBFC00000);
    chk("rst.vld", {31'd0, id_valid}, 32'd0);
    chk("rst.ins", id_instr, 32'd0);
    chk("rst.pc", id_pc, 32'd0);
    chk("rst.act", {31'd0, active}, 32'd1);
    chk("rst.flt", {31'd0, fault}, 32'd0);
    chk("rst.fa", fault_addr, 32'd0);

    // sequential fetch
    step(); chk("seq1.addr", instr_address, 32'hBFC00004); chk_id("seq1", 1'b1, 32'hBFC00000);
    step(); chk("seq2.addr", instr_address, 32'hBFC00008); chk_id("seq2", 1'b1, 32'hBFC00004);
    step(); chk("seq3.addr", instr_address, 32'hBFC0000C); chk_id("seq3", 1'b1, 32'hBFC00008);

    // redirect: delay slot BFC0000C captured, target next
    redirect_valid = 1'b1; redirect_target = 32'h20000000;
    step(); chk("rd.addr", instr_address, 32'h20000000); chk_id("rd.ds", 1'b1, 32'hBFC0000C);
    redirect_valid = 1'b0;
    step(); chk("rd2.addr", instr_address, 32'h20000004); chk_id("rd.tgt", 1'b1, 32'h20000000);

    // stall with pending redirect
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h30000000;
    for (int i = 0; i < 2; i++) begin
      step(); chk("stl.addr", instr_address, 32'h20000004); chk_id("stl", 1'b1, 32'h20000000);
    end
    stall = 1'b0;
    step(); chk("stl.rel.addr", instr_address, 32'h30000000); chk_id("stl.ds", 1'b1, 32'h20000004);
    redirect_valid = 1'b0;
    step(); chk("stl.tgt.addr", instr_address, 32'h30000004); chk_id("stl.tgt", 1'b1, 32'h30000000);

    // misaligned redirect
    redirect_valid = 1'b1; redirect_target = 32'h40000002;
    step();
    redirect_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("mis.flt", {31'd0, fault}, 32'd1);
    chk("mis.fa", fault_addr, 32'h40000002);
    chk("mis.act", {31'd0, active}, 32'd0);
    chk("mis.addr", instr_address, 32'h30000008);
    chk_id("mis.ds", 1'b1, 32'h30000004);
    step();
    chk("mis2.vld", {31'd0, id_valid}, 32'd0);
    chk("mis2.addr", instr_address, 32'h30000008);
    chk("mis2.flt", {31'd0, fault}, 32'd1);
`else
    chk("mis.flt", {31'd0, fault}, 32'd0);
    chk("mis.addr", instr_address, 32'h40000000);
    chk_id("mis.ds", 1'b1, 32'h30000004);
    step();
    chk("mis2.addr", instr_address, 32'h40000004);
    chk_id("mis2", 1'b1, 32'h40000000);
    chk("mis2.fa", fault_addr, 32'd0);
`endif

    // reset mid-stall, with a redirect also pending
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h50000000; reset_n = 1'b0;
    step();
    chk("rs.addr", instr_address, 32'hBFC00000);
    chk("rs.vld", {31'd0, id_valid}, 32'd0);
    chk("rs.pc", id_pc, 32'd0);
    chk("rs.ins", id_instr, 32'd0);
    chk("rs.act", {31'd0, active}, 32'd1);
    chk("rs.flt", {31'd0, fault}, 32'd0);
    reset_n = 1'b1; stall = 1'b0; redirect_valid = 1'b0;

    // sequential wrap past HALT_ADDR does not halt
    redirect_valid = 1'b1; redirect_target = 32'hFFFFFFF8;
    step(); chk("wr0.addr", instr_address, 32'hFFFFFFF8);
    redirect_valid = 1'b0;
    step(); chk("wr1.addr", instr_address, 32'hFFFFFFFC);
    step(); chk("wr2.addr", instr_address, 32'h00000000); chk("wr2.act", {31'd0, active}, 32'd1);
    step(); chk("wr3.addr", instr_address, 32'h00000004); chk("wr3.act", {31'd0, active}, 32'd1);
    chk_id("wr3", 1'b1, 32'h00000000);

    // jr r0: delay slot at 4 captured, then halted
    redirect_valid = 1'b1; redirect_target = 32'h00000000;
    step();
    chk("h.addr", instr_address, 32'h0);
    chk("h.act", {31'd0, active}, 32'd0);
    chk_id("h.ds", 1'b1, 32'h00000004);
    redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("h.frz.addr", instr_address, 32'h0);
      chk("h.frz.vld", {31'd0, id_valid}, 32'd0);
    end
    // a redirect while halted is ignored
    redirect_valid = 1'b1; redirect_target = 32'h60000000;
    step(); chk("h.rd.addr", instr_address, 32'h0); chk("h.rd.act", {31'd0, active}, 32'd0);
    redirect_valid = 1'b0;

    // reset while halted
    reset_n = 1'b0;
    step();
    chk("rh.addr", instr_address, 32'hBFC00000);
    chk("rh.act", {31'd0, active}, 32'd1);
    chk("rh.vld", {31'd0, id_valid}, 32'd0);
    reset_n = 1'b1;
    step(); chk("rh1.addr", instr_address, 32'hBFC00004); chk_id("rh1", 1'b1, 32'hBFC00000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
